branch_resolver: RTL and testbench

Flag consumer for the i281 control path. It accepts one decoded branch or jump from the control logic and waits until the flags register is stable. It then evaluates the branch condition against the stored C/O/N/Z flags and returns a one-cycle resolution carrying the taken decision and the next PC. It sits between the flags register outputs and the PC-load select (C-signal) of the control logic.

---
 rtl/i281_branch_pkg.sv | 23 ++
 rtl/branch_cond_eval.sv | 26 ++
 rtl/branch_resolver.sv | 108 ++++++++++
 tb/tb_branch_resolver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/i281_branch_pkg.sv
// i281_branch_pkg: shared types and constants for the i281 branch resolver.
package i281_branch_pkg;
    localparam int PC_W_DEFAULT = 6;
    localparam int OFS_W_DEFAULT = 8;
    localparam int STAT_W = 16;

    typedef enum logic [2:0] {
        C_JUMP = 3'd0,
        C_BRC  = 3'd1,
        C_BRO  = 3'd2,
        C_BRN  = 3'd3,
        C_BRZ  = 3'd4,
        C_BRNZ = 3'd5,
        C_BRG  = 3'd6,
        C_BRGE = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } br_state_e;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition check against C/O/N/Z flags.
module branch_cond_eval
    import i281_branch_pkg::*;
(
    input  cond_e cond,
    input  logic  c,
    input  logic  o,
    input  logic  n,
    input  logic  z,
    output logic  taken
);
    always_comb begin
        taken = 1'b1;
        case (cond)
            C_JUMP: taken = 1'b1;
            C_BRC:  taken = c;
            C_BRO:  taken = o;
            C_BRN:  taken = n;
            C_BRZ:  taken = z;
            C_BRNZ: taken = !z;
            C_BRG:  taken = !z && (n == o);
            C_BRGE: taken = n == o;
            default: taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: waits for stable flags, resolves one branch, returns taken + next PC.
// Optional saturating statistics counters under BRANCH_RESOLVER_STATS_EN.
module branch_resolver
    import i281_branch_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT,
    parameter int OFS_W = OFS_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [OFS_W-1:0]  br_offset,
    input  logic              flags_busy,
    input  logic              flag_carry,
    input  logic              flag_overflow,
    input  logic              flag_negative,
    input  logic              flag_zero,
    output logic              br_done,
    output logic              br_taken,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_next,
    output logic [STAT_W-1:0] stat_total,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_stall
);
    br_state_e state, state_n;
    cond_e cond_q;
    logic [PC_W-1:0] pc_q, pc_next_q, pc_inc, target;
    logic [OFS_W-1:0] ofs_q;
    logic taken_c, taken_q;

    branch_cond_eval u_cond (
        .cond  (cond_q),
        .c     (flag_carry),
        .o     (flag_overflow),
        .n     (flag_negative),
        .z     (flag_zero),
        .taken (taken_c)
    );

    // Size cast of the signed offset sign-extends or wraps it to PC width.
    assign pc_inc = pc_q + PC_W'(1);
    assign target = pc_inc + PC_W'($signed(ofs_q));

    always_ff @(posedge clk) begin
        state <= reset ? S_IDLE : state_n;
    end

    always_comb begin
        state_n = state;
        if (state == S_IDLE && br_valid) state_n = S_EVAL;
        else if (state == S_EVAL && !flags_busy) state_n = S_DONE;
        else if (state == S_DONE) state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cond_q    <= C_JUMP;
            pc_q      <= '0;
            ofs_q     <= '0;
            taken_q   <= 1'b0;
            pc_next_q <= '0;
        end else begin
            if (state == S_IDLE && br_valid) begin
                cond_q <= cond_e'(br_cond);
                pc_q   <= br_pc;
                ofs_q  <= br_offset;
            end
            if (state == S_EVAL && !flags_busy) begin
                taken_q   <= taken_c;
                pc_next_q <= taken_c ? target : pc_inc;
            end
        end
    end

    assign br_ready = state == S_IDLE;
    assign br_done  = state == S_DONE;
    assign br_taken = taken_q;
    assign pc_load  = br_done & taken_q;
    assign pc_next  = pc_next_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [STAT_W-1:0] total_q, taken_cnt_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q     <= '0;
            taken_cnt_q <= '0;
            stall_q     <= '0;
        end else begin
            if (state == S_DONE && total_q != '1) total_q <= total_q + STAT_W'(1);
            if (state == S_DONE && taken_q && taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + STAT_W'(1);
            if (state == S_EVAL && flags_busy && stall_q != '1) stall_q <= stall_q + STAT_W'(1);
        end
    end

    assign stat_total = total_q;
    assign stat_taken = taken_cnt_q;
    assign stat_stall = stall_q;
`else
    assign stat_total = '0;
    assign stat_taken = '0;
    assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed + random checks of branch_resolver against a flag/offset model.
module tb_branch_resolver;
    import i281_branch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [5:0]  br_pc;
    logic [7:0]  br_offset;
    logic        flags_busy;
    logic        flag_carry, flag_overflow, flag_negative, flag_zero;
    logic        br_done, br_taken, pc_load;
    logic [5:0]  pc_next;
    logic [15:0] stat_total, stat_taken, stat_stall;

    cond_e ue_cond;
    logic  uc, uo, un, uz, ue_taken;

    int checks = 0;
    int errors = 0;
    int m_total = 0, m_taken = 0, m_stall = 0;
    logic       gt;
    logic [5:0] gp;

    always #5 clk = ~clk;

    branch_resolver #(.PC_W(6), .OFS_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_cond       (br_cond),
        .br_pc         (br_pc),
        .br_offset     (br_offset),
        .flags_busy    (flags_busy),
        .flag_carry    (flag_carry),
        .flag_overflow (flag_overflow),
        .flag_negative (flag_negative),
        .flag_zero     (flag_zero),
        .br_done       (br_done),
        .br_taken      (br_taken),
        .pc_load       (pc_load),
        .pc_next       (pc_next),
        .stat_total    (stat_total),
        .stat_taken    (stat_taken),
        .stat_stall    (stat_stall)
    );

    branch_cond_eval u_eval (
        .cond  (ue_cond),
        .c     (uc),
        .o     (uo),
        .n     (un),
        .z     (uz),
        .taken (ue_taken)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Truth table indexed by condition code, built from the flag equations.
    function automatic logic ref_taken(input logic [2:0] cond, input logic c, o, n, z);
        logic [7:0] t;
        t = {n == o, !z && (n == o), !z, z, n, o, c, 1'b1};
        return t[cond];
    endfunction

    function automatic logic [5:0] ref_pc(input logic [5:0] pc, input logic [7:0] ofs, input logic tk);
        int s;
        int t;
        s = (int'(ofs) > 127) ? int'(ofs) - 256 : int'(ofs);
        t = int'(pc) + 1 + (tk ? s : 0);
        return 6'(((t % 64) + 64) % 64);
    endfunction

    task automatic check_stats;
`ifdef BRANCH_RESOLVER_STATS_EN
        check("stat_total", stat_total, m_total);
        check("stat_taken", stat_taken, m_taken);
        check("stat_stall", stat_stall, m_stall);
`else
        check("stat_total_tied", stat_total, 0);
        check("stat_taken_tied", stat_taken, 0);
        check("stat_stall_tied", stat_stall, 0);
`endif
    endtask

    task automatic run(input logic [2:0] cond, input logic [5:0] pc, input logic [7:0] ofs,
                       input logic c, o, n, z, input int stall,
                       output logic got_t, output logic [5:0] got_pc);
        int lat;
        logic et;
        logic [5:0] ep;
        et = ref_taken(cond, c, o, n, z);
        ep = ref_pc(pc, ofs, et);
        @(negedge clk);
        check("ready_idle", br_ready, 1);
        br_valid = 1'b1;
        br_cond = cond;
        br_pc = pc;
        br_offset = ofs;
        {flag_carry, flag_overflow, flag_negative, flag_zero} = 4'($urandom);
        flags_busy = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (br_done) break;
            if (lat == 1) begin
                check("ready_eval", br_ready, 0);
                br_valid = 1'b0;
                br_cond = 3'($urandom);
                br_pc = 6'($urandom);
                br_offset = 8'($urandom);
            end
            flags_busy = lat <= stall;
            {flag_carry, flag_overflow, flag_negative, flag_zero} = flags_busy ? 4'($urandom) : {c, o, n, z};
        end while (lat < stall + 10);
        check("latency", lat, stall + 2);
        check("done", br_done, 1);
        check("taken", br_taken, et);
        check("pc_load", pc_load, et);
        check("pc_next", pc_next, ep);
        check("ready_done", br_ready, 0);
        got_t = br_taken;
        got_pc = pc_next;
        m_total++;
        m_taken += int'(et);
        m_stall += stall;
        br_valid = 1'b1;
        flags_busy = 1'($urandom);
        {flag_carry, flag_overflow, flag_negative, flag_zero} = 4'($urandom);
        @(negedge clk);
        check("no_accept_in_done", br_ready, 1);
        br_valid = 1'b0;
        flags_busy = 1'b0;
        check_stats();
    endtask

    initial begin
        reset = 1'b1;
        br_valid = 1'b0;
        br_cond = '0;
        br_pc = '0;
        br_offset = '0;
        flags_busy = 1'b0;
        {flag_carry, flag_overflow, flag_negative, flag_zero} = 4'b0;

        for (int i = 0; i < 8; i++) begin
            for (int f = 0; f < 16; f++) begin
                ue_cond = cond_e'(3'(i));
                {uc, uo, un, uz} = 4'(f);
                #1;
                check("cond_eval", ue_taken, ref_taken(3'(i), uc, uo, un, uz));
            end
        end

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", br_ready, 1);
        check("rst_done", br_done, 0);
        check("rst_taken", br_taken, 0);
        check("rst_pc_load", pc_load, 0);
        check("rst_pc_next", pc_next, 0);
        check_stats();

        run(3'd0, 6'd10, 8'd5, 0, 0, 0, 0, 0, gt, gp);
        check("jump_pc", gp, 16);
        run(3'd4, 6'd3, 8'd9, 0, 0, 0, 0, 0, gt, gp);
        check("brz_nt_taken", gt, 0);
        check("brz_nt_pc", gp, 4);
        run(3'd4, 6'd3, 8'hFE, 0, 0, 0, 1, 0, gt, gp);
        check("brz_t_pc", gp, 2);

        for (int k = 6; k < 8; k++) begin
            for (int f = 0; f < 16; f++) begin
                logic [3:0] fl;
                fl = 4'(f);
                run(3'(k), 6'($urandom), 8'($urandom), fl[3], fl[2], fl[1], fl[0], 0, gt, gp);
            end
        end
        run(3'd6, 6'd20, 8'd4, 0, 1, 1, 0, 0, gt, gp);
        check("brg_n1o1_taken", gt, 1);

        run(3'd0, 6'd62, 8'd3, 0, 0, 0, 0, 0, gt, gp);
        check("wrap_up", gp, 2);
        run(3'd0, 6'd0, 8'h80, 0, 0, 0, 0, 0, gt, gp);
        check("wrap_down", gp, 1);

        run(3'd4, 6'd7, 8'd2, 0, 0, 0, 1, 3, gt, gp);
        check("stall_taken", gt, 1);

        for (int r = 0; r < 40; r++) begin
            logic [3:0] fl;
            fl = 4'($urandom);
            run(3'($urandom), 6'($urandom), 8'($urandom), fl[3], fl[2], fl[1], fl[0],
                int'($urandom_range(0, 3)), gt, gp);
        end

        @(negedge clk);
        br_valid = 1'b1;
        br_cond = 3'd0;
        br_pc = 6'd33;
        br_offset = 8'd1;
        @(negedge clk);
        check("rst_eval_ready_before", br_ready, 0);
        br_valid = 1'b0;
        flags_busy = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        flags_busy = 1'b0;
        check("rst_eval_ready", br_ready, 1);
        check("rst_eval_done", br_done, 0);
        check("rst_eval_pc_load", pc_load, 0);
        check("rst_eval_taken", br_taken, 0);
        check("rst_eval_pc_next", pc_next, 0);
        m_total = 0;
        m_taken = 0;
        m_stall = 0;
        check_stats();
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            check("dropped_no_done", br_done, 0);
        end
        run(3'd1, 6'd5, 8'd10, 1, 0, 0, 0, 1, gt, gp);
        check("after_rst_pc", gp, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
